// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared command encodings, widths and frame layout for the
// SPI-to-RAM command controller.
package spi_ram_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    // Command field carried in frame bits [9:8]
    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    // One received SPI frame: command on top, byte payload below
    typedef struct packed {
        cmd_e              cmd;
        logic [DATA_W-1:0] payload;
    } frame_t;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// spi_ram_ctrl_if: frame/read-back link between the SPI slave receiver
// (master modport) and the RAM command controller (slave modport).
interface spi_ram_ctrl_if;
    import spi_ram_pkg::*;

    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    // SPI slave side: delivers frames, shifts read bytes out on MISO
    modport master (
        output rx_data,
        output rx_valid,
        input  tx_data,
        input  tx_valid
    );

    // Controller side: decodes frames, returns read bytes
    modport slave (
        input  rx_data,
        input  rx_valid,
        output tx_data,
        output tx_valid
    );

endinterface

// File: rtl/spi_ram_array.sv
// spi_ram_array: single-port synchronous RAM, write-enable plus registered
// read with read-enable. Contents are never reset so it maps onto block RAM;
// the read register only moves on re, so rdata holds between reads.
module spi_ram_array
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem_reg [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    // Write port and registered read share the single address
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem_reg[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: decodes 10-bit SPI frames into write-address, write-data,
// read-address and read-data operations on an internal RAM, returning read
// bytes via tx_data/tx_valid one clock after the accepting edge.
// Optional build macro SPI_RAM_ADDR_AUTOINC_EN: post-increment wr_addr after
// WR_DATA and rd_addr after RD_DATA, wrapping MEM_DEPTH-1 -> 0.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_ram_ctrl_if.slave  bus
);

    frame_t                frame;
    cmd_e                  cmd;
    logic [DATA_W-1:0]     payload;
    logic                  accept;

    logic                  rx_valid_d_reg;
    logic [ADDR_SIZE-1:0]  wr_addr_reg, wr_addr_next;
    logic [ADDR_SIZE-1:0]  rd_addr_reg, rd_addr_next;
    logic                  tx_valid_reg, tx_valid_next;
    // High when the last read returned a real RAM byte; low after reset or
    // after an out-of-range read, which forces tx_data to zero.
    logic                  tx_live_reg, tx_live_next;

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_SIZE-1:0]  ram_addr;
    logic [DATA_W-1:0]     ram_rdata;
    logic [DATA_W-1:0]     tx_data_masked;

    assign frame   = frame_t'(bus.rx_data);
    assign cmd     = frame.cmd;
    assign payload = frame.payload;

    // Rising edge of rx_valid only: a held rx_valid executes once
    assign accept = bus.rx_valid & ~rx_valid_d_reg;

    // Address width may cover more than MEM_DEPTH; compare at 32 bits so the
    // default 256-deep / 8-bit case does not truncate the bound.
    assign wr_in_range = (32'(wr_addr_reg) < 32'(MEM_DEPTH));
    assign rd_in_range = (32'(rd_addr_reg) < 32'(MEM_DEPTH));

`ifdef SPI_RAM_ADDR_AUTOINC_EN
    function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
        if (32'(a) == 32'(MEM_DEPTH - 1)) begin
            return '0;
        end
        return a + 1'b1;
    endfunction
`endif

    // Edge-detect register; resets high so a level already present at reset
    // release is not mistaken for a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_d_reg <= 1'b1;
        end else begin
            rx_valid_d_reg <= bus.rx_valid;
        end
    end

    // Command decode: next address registers and read-back handshake
    always_comb begin
        wr_addr_next  = wr_addr_reg;
        rd_addr_next  = rd_addr_reg;
        tx_valid_next = tx_valid_reg;
        tx_live_next  = tx_live_reg;
        if (accept) begin
            // Any accepted command retires the previous read-back byte
            tx_valid_next = 1'b0;
            case (cmd)
                CMD_WR_ADDR: begin
                    wr_addr_next = payload[ADDR_SIZE-1:0];
                end
                CMD_WR_DATA: begin
`ifdef SPI_RAM_ADDR_AUTOINC_EN
                    wr_addr_next = addr_inc(wr_addr_reg);
`endif
                end
                CMD_RD_ADDR: begin
                    rd_addr_next = payload[ADDR_SIZE-1:0];
                end
                CMD_RD_DATA: begin
                    tx_valid_next = 1'b1;
                    tx_live_next  = rd_in_range;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
                    rd_addr_next  = addr_inc(rd_addr_reg);
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Address and handshake state, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_reg  <= '0;
            rd_addr_reg  <= '0;
            tx_valid_reg <= 1'b0;
            tx_live_reg  <= 1'b0;
        end else begin
            wr_addr_reg  <= wr_addr_next;
            rd_addr_reg  <= rd_addr_next;
            tx_valid_reg <= tx_valid_next;
            tx_live_reg  <= tx_live_next;
        end
    end

    // Out-of-range accesses never touch the RAM; the read register then keeps
    // its old byte and the tx mask hides it.
    assign ram_we   = accept && (cmd == CMD_WR_DATA) && wr_in_range;
    assign ram_re   = accept && (cmd == CMD_RD_DATA) && rd_in_range;
    assign ram_addr = (cmd == CMD_WR_DATA) ? wr_addr_reg : rd_addr_reg;

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (payload),
        .rdata (ram_rdata)
    );

    // Gate each read-back bit so reset clears tx_data without resetting RAM
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_tx_mask
        assign tx_data_masked[gi] = ram_rdata[gi] & tx_live_reg;
    end

    assign bus.tx_data  = tx_data_masked;
    assign bus.tx_valid = tx_valid_reg;

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Command-decoding memory controller that sits directly downstream of the SPI slave receiver.
- Consumes each 10-bit frame (rx_data, rx_valid): bits [9:8] are the command, bits [7:0] are the payload.
- Executes write-address, write-data, read-address and read-data operations on an internal synchronous RAM.
- Returns read bytes to the SPI slave through tx_data/tx_valid, which the slave shifts out on MISO.

Parameters:
MEM_DEPTH, 256, number of 8-bit words in the RAM; legal range 2..2**ADDR_SIZE.
ADDR_SIZE, 8, address register width; must not exceed the 8-bit payload width.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
rx_data  input  10  frame from SPI slave; [9:8] command, [7:0] payload.
rx_valid  input  1  frame-valid from SPI slave; may stay high for several cycles per frame.
tx_data  output  8  read-back byte to SPI slave.
tx_valid  output  1  tx_data valid; held high while the slave shifts the byte out.

Behaviour:
Reset:
- Reset is asynchronous on rst_n, active-low; clock is clk.
- On reset: tx_data=0, tx_valid=0, wr_addr=0, rd_addr=0, rx_valid_d=1.
- RAM contents are not reset.
- rx_valid_d resets to 1 so that an rx_valid already high at reset release is not accepted.

Frame acceptance:
- accept = rx_valid & ~rx_valid_d, where rx_valid_d is rx_valid registered every cycle.
- Exactly one command executes per rx_valid rising edge; a held rx_valid never re-executes the command.

Commands, each executing on the clock edge where accept=1:
- 2'b00 WR_ADDR: wr_addr <= payload[ADDR_SIZE-1:0].
- 2'b01 WR_DATA: mem[wr_addr] <= payload.
- 2'b10 RD_ADDR: rd_addr <= payload[ADDR_SIZE-1:0].
- 2'b11 RD_DATA: tx_data <= mem[rd_addr]; tx_valid <= 1.

tx_valid and tx_data:
- Read latency: tx_data and tx_valid are valid 1 clk after the accept cycle.
- tx_valid stays high until the next accepted command of any type, which clears it on that same edge; a back-to-back RD_DATA re-asserts it.
- tx_data holds its last value when tx_valid=0.

Address range:
- An address >= MEM_DEPTH makes WR_DATA a no-op.
- RD_DATA from an address >= MEM_DEPTH returns 8'h00 with tx_valid=1.

Ordering and boundary conditions:
- Commands are strictly serialized, so there are no read/write collisions.
- RD_DATA after WR_DATA to the same address returns the newly written byte.
- Reset mid-operation clears tx_valid immediately; the command in flight is discarded.
- No state machine beyond the edge detector; the controller is otherwise stateless between frames apart from its address registers.

Optional Feature:
Macro: SPI_RAM_ADDR_AUTOINC_EN
- Defined:
  - After each WR_DATA, wr_addr <= wr_addr+1.
  - After each RD_DATA, rd_addr <= rd_addr+1.
  - Both wrap modulo MEM_DEPTH: address MEM_DEPTH-1 rolls to 0.
  - Increment occurs on the same edge as the access; the next access uses the new address.
- Undefined:
  - Addresses change only on WR_ADDR and RD_ADDR.

Decomposition:
Package spi_ram_pkg holds:
- CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
- FRAME_W=10, DATA_W=8.

Sub-module spi_ram_array:
- Single-port synchronous RAM with write-enable and registered read.
- Parameterised by MEM_DEPTH and ADDR_SIZE.
- Instantiated once; the top keeps decode, address registers, edge detect and tx handshake.

Test Plan:
1. Reset release with rx_valid held high, frame 10'h0_55 -> no command executes; wr_addr stays 0; tx_valid=0.
2. Frames 10'h0_3A, 10'h1_C5, 10'h2_3A, 10'h3_00, each rx_valid pulse 1 clk -> tx_data=8'hC5 and tx_valid=1 exactly 1 clk after the 4th accept; next WR_ADDR frame clears tx_valid.
3. WR_DATA frame with rx_valid held high 5 clk -> exactly one RAM write; following read of that address returns the payload.
4. MEM_DEPTH=200: WR_ADDR 8'hF0, WR_DATA 8'hAA, RD_ADDR 8'hF0, RD_DATA -> tx_data=8'h00; location 0 is unchanged.
5. rst_n pulled low 1 clk after RD_DATA accept -> tx_valid=0 and tx_data=0 asynchronously, before the next clk edge.
6. With SPI_RAM_ADDR_AUTOINC_EN defined, MEM_DEPTH=256: WR_ADDR 8'hFF, WR_DATA 8'h11, WR_DATA 8'h22, RD_ADDR 8'hFF, then RD_DATA twice -> returns 8'h11, then 8'h22 (address wraps to 0).
